// File: rtl/peri_7seg_pkg.sv
// Shared types and constants for the 7-segment write scheduler.
// Imported by the arbiter and the scheduler top.
package peri_7seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        HOLD
    } sched_state_t;

    localparam int DISP_W         = 16;
    localparam int HOLD_1MS_10MHZ = 10000;

endpackage

// File: rtl/peri_7seg_sched_rr_arb_2.sv
// Two-input round-robin grant, purely combinational.
// A lone request always wins; on a tie the side not granted last wins.
module rr_arb_2
    import peri_7seg_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
        gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
    end

endmodule

// File: rtl/peri_7seg_sched.sv
// Write scheduler for peri_7seg: arbitrates two requesters, issues a
// one-cycle strobe with registered data, then holds the value visible.
module peri_7seg_sched
    import peri_7seg_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_1MS_10MHZ,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_valid_i,
    input  logic [DISP_W-1:0] cpu_d_i,
    output logic              cpu_ready_o,
    input  logic              dbg_valid_i,
    input  logic [DISP_W-1:0] dbg_d_i,
    output logic              dbg_ready_o,
    output logic              we_7seg_o,
    output logic [DISP_W-1:0] d_7seg_o,
    output logic              busy_o
);

    // HOLD_CYCLES=0 still needs a legal one-bit counter
    localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic [CW-1:0] HOLD_LOAD =
        (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

    sched_state_t      state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [DISP_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic [1:0]        gnt;
    logic              idle;

    rr_arb_2 u_arb (
        .req_i  ({dbg_valid_i, cpu_valid_i}),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    // Readies stay low while reset is held, even with valids present
    assign idle        = (state_q == IDLE) & rst_i;
    assign cpu_ready_o = idle & gnt[0];
    assign dbg_ready_o = idle & gnt[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        data_d  = data_q;
        we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d = WRITE;
                    we_d    = 1'b1;
                    last_d  = gnt[1];
                    data_d  = gnt[1] ? dbg_d_i : cpu_d_i;
                end
            end
            WRITE: begin
                if (HOLD_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            data_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
        end
    end

    assign we_7seg_o = we_q;
    assign d_7seg_o  = data_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_peri_7seg_sched.sv
// Directed bench for peri_7seg_sched: HOLD_CYCLES=4 main instance
// plus a HOLD_CYCLES=0 instance for back-to-back strobes.
module tb_peri_7seg_sched;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        cpu_valid = 1'b0, dbg_valid = 1'b0;
    logic [15:0] cpu_d = '0, dbg_d = '0;
    logic        cpu_ready, dbg_ready, we, busy;
    logic [15:0] d_out;

    logic        cpu_valid0 = 1'b0, dbg_valid0 = 1'b0;
    logic [15:0] cpu_d0 = '0, dbg_d0 = '0;
    logic        cpu_ready0, dbg_ready0, we0, busy0;
    logic [15:0] d_out0;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    peri_7seg_sched #(.HOLD_CYCLES(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_valid_i (cpu_valid),
        .cpu_d_i     (cpu_d),
        .cpu_ready_o (cpu_ready),
        .dbg_valid_i (dbg_valid),
        .dbg_d_i     (dbg_d),
        .dbg_ready_o (dbg_ready),
        .we_7seg_o   (we),
        .d_7seg_o    (d_out),
        .busy_o      (busy)
    );

    peri_7seg_sched #(.HOLD_CYCLES(0)) dut0 (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_valid_i (cpu_valid0),
        .cpu_d_i     (cpu_d0),
        .cpu_ready_o (cpu_ready0),
        .dbg_valid_i (dbg_valid0),
        .dbg_d_i     (dbg_d0),
        .dbg_ready_o (dbg_ready0),
        .we_7seg_o   (we0),
        .d_7seg_o    (d_out0),
        .busy_o      (busy0)
    );

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, need 0", busy, n);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_valid = 1'($urandom_range(1));
            dbg_valid = 1'($urandom_range(1));
            cpu_d = 16'h1111;
            dbg_d = 16'h2222;
            #1;
            vecs++;
            if ({cpu_ready, dbg_ready} !== 2'b00) begin
                errs++;
                $display("FAIL reset_ready: got %b need 00", {cpu_ready, dbg_ready});
            end
            vecs++;
            if ({we, busy, d_out} !== 18'h0) begin
                errs++;
                $display("FAIL reset_out: we=%b busy=%b d=%h need 0 0 0000", we, busy, d_out);
            end
        end
        @(negedge clk);
        cpu_valid = 1'b0;
        dbg_valid = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        vecs++;
        if ({we, busy, d_out} !== 18'h0) begin
            errs++;
            $display("FAIL reset_release: we=%b busy=%b d=%h need idle", we, busy, d_out);
        end
    endtask

    task automatic test_single_cpu();
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_d = 16'h1234;
        #1;
        vecs++;
        if ({cpu_ready, dbg_ready} !== 2'b10) begin
            errs++;
            $display("FAIL single_ready: got %b need 10", {cpu_ready, dbg_ready});
        end
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            cpu_valid = 1'b0;
            #1;
            vecs++;
            if (we !== (i == 1)) begin
                errs++;
                $display("FAIL single_we c%0d: got %b need %b", i, we, (i == 1));
            end
            vecs++;
            if (busy !== (i <= 5)) begin
                errs++;
                $display("FAIL single_busy c%0d: got %b need %b", i, busy, (i <= 5));
            end
            vecs++;
            if (d_out !== 16'h1234) begin
                errs++;
                $display("FAIL single_data c%0d: got %h need 1234", i, d_out);
            end
        end
    endtask

    task automatic test_alternate();
        logic [15:0] exp_d;
        logic [1:0]  exp_rdy;
        rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        cpu_valid = 1'b1;
        cpu_d = 16'hAAAA;
        dbg_valid = 1'b1;
        dbg_d = 16'h5555;
        for (int i = 0; i <= 13; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_rdy = (i == 0 || i == 12) ? 2'b10 : (i == 6) ? 2'b01 : 2'b00;
            vecs++;
            if ({cpu_ready, dbg_ready} !== exp_rdy) begin
                errs++;
                $display("FAIL alt_ready c%0d: got %b need %b", i, {cpu_ready, dbg_ready}, exp_rdy);
            end
            vecs++;
            if (we !== (i == 1 || i == 7 || i == 13)) begin
                errs++;
                $display("FAIL alt_we c%0d: got %b", i, we);
            end
            if (i == 1 || i == 7 || i == 13) begin
                exp_d = (i == 7) ? 16'h5555 : 16'hAAAA;
                vecs++;
                if (d_out !== exp_d) begin
                    errs++;
                    $display("FAIL alt_data c%0d: got %h need %h", i, d_out, exp_d);
                end
            end
        end
        cpu_valid = 1'b0;
        dbg_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_dbg_during_hold();
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_d = 16'hBEEF;
        #1;
        vecs++;
        if (cpu_ready !== 1'b1) begin
            errs++;
            $display("FAIL hold_cpu_ready: got %b need 1", cpu_ready);
        end
        @(negedge clk);
        cpu_valid = 1'b0;
        for (int i = 2; i <= 6; i++) begin
            @(negedge clk);
            dbg_valid = 1'b1;
            dbg_d = 16'h0F0F;
            #1;
            vecs++;
            if ({cpu_ready, dbg_ready} !== ((i == 6) ? 2'b01 : 2'b00)) begin
                errs++;
                $display("FAIL hold_ready c%0d: got %b", i, {cpu_ready, dbg_ready});
            end
        end
        @(negedge clk);
        dbg_valid = 1'b0;
        #1;
        vecs++;
        if ({we, d_out} !== {1'b1, 16'h0F0F}) begin
            errs++;
            $display("FAIL hold_dbg_write: we=%b d=%h need 1 0f0f", we, d_out);
        end
        wait_idle();
    endtask

    task automatic test_reset_during_we();
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_d = 16'hC0DE;
        @(negedge clk);
        cpu_d = 16'h7777;
        #1;
        vecs++;
        if ({we, d_out} !== {1'b1, 16'hC0DE}) begin
            errs++;
            $display("FAIL rstwe_pre: we=%b d=%h need 1 c0de", we, d_out);
        end
        #1;
        rst_i = 1'b0;
        #1;
        vecs++;
        if ({we, busy, d_out} !== 18'h0) begin
            errs++;
            $display("FAIL rstwe_async: we=%b busy=%b d=%h need 0", we, busy, d_out);
        end
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        vecs++;
        if (cpu_ready !== 1'b1) begin
            errs++;
            $display("FAIL rstwe_ready: got %b need 1", cpu_ready);
        end
        @(negedge clk);
        cpu_valid = 1'b0;
        #1;
        vecs++;
        if ({we, d_out} !== {1'b1, 16'h7777}) begin
            errs++;
            $display("FAIL rstwe_serve: we=%b d=%h need 1 7777", we, d_out);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rdy;
        cpu_valid0 = 1'b1;
        cpu_d0 = 16'hAAAA;
        dbg_valid0 = 1'b1;
        dbg_d0 = 16'h5555;
        for (int i = 0; i <= 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_rdy = (i == 2) ? 2'b01 : (i[0] == 1'b0) ? 2'b10 : 2'b00;
            vecs++;
            if ({cpu_ready0, dbg_ready0} !== exp_rdy) begin
                errs++;
                $display("FAIL b2b_ready c%0d: got %b need %b", i, {cpu_ready0, dbg_ready0}, exp_rdy);
            end
            vecs++;
            if ({we0, busy0} !== {i[0], i[0]}) begin
                errs++;
                $display("FAIL b2b_we c%0d: we=%b busy=%b need %b", i, we0, busy0, i[0]);
            end
            if (i[0]) begin
                vecs++;
                if (d_out0 !== ((i == 3) ? 16'h5555 : 16'hAAAA)) begin
                    errs++;
                    $display("FAIL b2b_data c%0d: got %h", i, d_out0);
                end
            end
        end
        cpu_valid0 = 1'b0;
        dbg_valid0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_cpu();
        test_alternate();
        test_dbg_during_hold();
        test_reset_during_we();
        test_back_to_back();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/peri_7seg_sched.md
# peri_7seg_sched

Write scheduler and 2-way arbiter in front of the 7-segment peripheral. Two requesters (CPU bus write path, debug/status source) compete to update the 16-bit display value; the block grants one at a time round-robin, issues a single-cycle write strobe plus registered data to `peri_7seg`, then enforces a minimum hold time so each value stays visible before the next update.

## Interface
- `HOLD_CYCLES`, default 10000: minimum display time after each write, in `clk_i` cycles (1 ms at 10 MHz); 0 disables hold.
- `CNT_W`, default `$clog2(HOLD_CYCLES+1)`: hold counter width; derived, never overridden.

- `clk_i`  in  1  system clock, 10 MHz; the block's only clock.
- `rst_i`  in  1  asynchronous, active-low reset.
- `cpu_valid_i`  in  1  requester 0 has data pending.
- `cpu_d_i`  in  16  requester 0 data.
- `cpu_ready_o`  out  1  requester 0 data accepted this cycle.
- `dbg_valid_i`  in  1  requester 1 has data pending.
- `dbg_d_i`  in  16  requester 1 data.
- `dbg_ready_o`  out  1  requester 1 data accepted this cycle.
- `we_7seg_o`  out  1  write strobe to `peri_7seg`, one cycle.
- `d_7seg_o`  out  16  registered data to `peri_7seg`.
- `busy_o`  out  1  high in WRITE or HOLD.

## Operation
- FSM states: IDLE, WRITE, HOLD.
- IDLE: when at least one valid is high, a grant goes to exactly one requester; the matching ready is driven high combinationally and a transfer occurs (valid && ready). Go to WRITE.
- Arbitration: a single valid is always granted. With both valid, grant goes to the requester not granted last (`last_q`). `last_q` resets to 1, so requester 0 wins the first tie. `last_q` updates only on a transfer.
- On transfer: `d_7seg_o` loads the granted data and `we_7seg_o` is set for the next cycle.
- WRITE: `we_7seg_o` = 1 for exactly this cycle. Next state is HOLD with the counter loaded to `HOLD_CYCLES-1`; if `HOLD_CYCLES` = 0, next state is IDLE.
- HOLD: counter decrements each cycle. Leave for IDLE when the counter is 0. Both readies are low.
- Readies are low outside IDLE and low for the non-granted requester.
- Requesters hold valid and data stable until ready. A valid that drops before ready is simply not served, and no state is kept for it.
- `d_7seg_o` holds the last written value indefinitely and is never cleared except by reset.

## Timing
- Reset values: state IDLE; `d_7seg_o` = 16'h0000; `we_7seg_o` = 0; `busy_o` = 0; both readies 0 while reset is asserted; counter 0; `last_q` = 1.
- Transfer in cycle N:
  - `d_7seg_o` is valid from N+1.
  - `we_7seg_o` is high only in N+1.
  - `peri_7seg` captures the data at the end of N+1.
- Next ready is possible at the earliest in cycle N+2+`HOLD_CYCLES`, which gives a throughput of one write per `HOLD_CYCLES`+2 cycles.
- `busy_o` is high from N+1 through N+1+`HOLD_CYCLES`.
- Reset asserted mid-WRITE or mid-HOLD: all outputs return to reset values asynchronously, and any pending strobe is dropped.
- A valid arriving during WRITE/HOLD waits. Grant is decided at IDLE re-entry using the current valids, not their arrival order.
- Outputs `we_7seg_o`, `d_7seg_o` and `busy_o` are registered. The readies are combinational from the valids, state and `last_q`.

## Structure
- Shared package `peri_7seg_pkg`:
  - `sched_state_t` enum {IDLE, WRITE, HOLD}.
  - `DISP_W` = 16.
  - `HOLD_1MS_10MHZ` = 10000.
- One sub-module, `rr_arb_2`: a 2-input round-robin grant (inputs: two valids, `last_q`; outputs: one-hot grant). It is purely combinational; `last_q` stays in the top.
- Top holds the FSM, hold counter, data register and strobe register.

## Test plan
Bench uses `HOLD_CYCLES`=4.
- Reset: hold `rst_i` low with random valids → readies 0, `we_7seg_o` 0, `d_7seg_o` 16'h0000. Release → first cycle in IDLE.
- Single CPU write 16'h1234 at cycle N → `cpu_ready_o` high in N; `we_7seg_o` high only in N+1 with `d_7seg_o`=16'h1234; `busy_o` high N+1..N+5; IDLE at N+6.
- Both valid continuously (cpu 16'hAAAA, dbg 16'h5555) after reset → writes alternate cpu, dbg, cpu, each 6 cycles apart.
- Debug valid raised during HOLD of a CPU write → dbg accepted in the first IDLE cycle, not before; no ready pulses during HOLD.
- Reset asserted in the cycle `we_7seg_o` is high → strobe drops immediately and `d_7seg_o` returns to 0. After release a pending valid is served normally.
- `HOLD_CYCLES`=0 build, both valid → a write strobe every 2 cycles, alternating requesters.
